// File: rtl/multicore_out_collector.sv
// Collects per-core results into one tagged first-word fall-through stream.
// Each core has a one-deep holding register that a round-robin arbiter drains into the FIFO.
module multicore_out_collector #(
   parameter int N_CORES    = 72,
   parameter int DATA_W     = 28,
   parameter int EN_W       = 4,
   parameter int IDX_W      = 7,
   parameter int FIFO_DEPTH = 16,
   parameter int DROP_W     = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [N_CORES*DATA_W-1:0]         io_out_bus,
   input  logic [N_CORES*EN_W-1:0]           out_en_bus,
   output logic signed [DATA_W-1:0]          dout,
   output logic [IDX_W-1:0]                  dout_core,
   output logic                              dout_valid,
   input  logic                              dout_ready,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
   output logic [N_CORES-1:0]                overrun,
   output logic [DROP_W-1:0]                 drop_count,
   input  logic                              clr_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(N_CORES + 1);
   localparam int EW = DATA_W + IDX_W;

   logic [N_CORES-1:0]        hold_v;
   logic [DATA_W-1:0]         hold_d [N_CORES];
   logic [IDX_W-1:0]          rr_ptr;
   logic [EW-1:0]             mem [FIFO_DEPTH];
   logic [AW-1:0]             wr_ptr;
   logic [AW-1:0]             rd_ptr;
   logic [EW-1:0]             head;

   logic [N_CORES-1:0]        ev;
   logic [N_CORES-1:0]        take;
   logic [N_CORES-1:0]        drop_vec;
   logic [CW-1:0]             drop_n;
   logic                      grant_found;
   logic [IDX_W-1:0]          grant_idx;
   logic [IDX_W:0]            idx_w;
   logic                      full;
   logic                      pop;
   logic                      push;
   logic [DROP_W-1:0]         drop_base;
   logic [DROP_W:0]           drop_sum;
   logic [DROP_W-1:0]         drop_next;

   // First holding core at or after rr_ptr, wrapping at N_CORES.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      idx_w       = '0;
      for (int i = 0; i < N_CORES; i++) begin
         idx_w = (IDX_W+1)'(rr_ptr) + (IDX_W+1)'(i);
         if (idx_w >= (IDX_W+1)'(N_CORES))
            idx_w = idx_w - (IDX_W+1)'(N_CORES);
         if (!grant_found && hold_v[idx_w[IDX_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = idx_w[IDX_W-1:0];
         end
      end
   end

   assign full = (fifo_level == LW'(FIFO_DEPTH));
   assign pop  = dout_valid & dout_ready;
   assign push = grant_found & (~full | pop);

   always_comb begin
      ev       = '0;
      take     = '0;
      drop_vec = '0;
      drop_n   = '0;
      for (int k = 0; k < N_CORES; k++) begin
         ev[k]       = (out_en_bus[k*EN_W +: EN_W] == EN_W'(1));
         take[k]     = push && (grant_idx == IDX_W'(k));
         drop_vec[k] = ev[k] & hold_v[k] & ~take[k];
         drop_n      = drop_n + CW'(drop_vec[k]);
      end
   end

   // A same-cycle clear only removes history; this cycle's drops still count.
   assign drop_base = clr_err ? '0 : drop_count;
   assign drop_sum  = {1'b0, drop_base} + (DROP_W+1)'(drop_n);
   assign drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_v <= '0;
         for (int k = 0; k < N_CORES; k++)
            hold_d[k] <= '0;
      end else begin
         for (int k = 0; k < N_CORES; k++) begin
            if (ev[k] && (!hold_v[k] || take[k])) begin
               hold_d[k] <= io_out_bus[k*DATA_W +: DATA_W];
               hold_v[k] <= 1'b1;
            end else if (take[k]) begin
               hold_v[k] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun    <= '0;
         drop_count <= '0;
         rr_ptr     <= '0;
      end else begin
         overrun    <= (clr_err ? '0 : overrun) | drop_vec;
         drop_count <= drop_next;
         if (push)
            rr_ptr <= (grant_idx == IDX_W'(N_CORES-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Storage needs no reset: only entries below fifo_level are ever visible.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {hold_d[grant_idx], grant_idx};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   assign head       = mem[rd_ptr];
   assign dout_valid = (fifo_level != '0);
   assign dout       = dout_valid ? $signed(head[EW-1:IDX_W]) : '0;
   assign dout_core  = dout_valid ? head[IDX_W-1:0] : '0;

endmodule

// File: tb/tb_multicore_out_collector.sv
// Directed bench for multicore_out_collector: vector table for single events,
// hand-written sequences for arbitration, backpressure, overrun and reset.
module tb_multicore_out_collector;

   localparam int N = 72;
   localparam int DW = 28;
   localparam int EW = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N*DW-1:0]      io_out_bus;
   logic [N*EW-1:0]      out_en_bus;
   logic signed [DW-1:0] dout;
   logic [6:0]           dout_core;
   logic                 dout_valid;
   logic                 dout_ready;
   logic [4:0]           fifo_level;
   logic [N-1:0]         overrun;
   logic [15:0]          drop_count;
   logic                 clr_err;

   int tests = 0;
   int fails = 0;

   multicore_out_collector dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .io_out_bus (io_out_bus),
      .out_en_bus (out_en_bus),
      .dout       (dout),
      .dout_core  (dout_core),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .fifo_level (fifo_level),
      .overrun    (overrun),
      .drop_count (drop_count),
      .clr_err    (clr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                   core;
      logic [3:0]           en;
      logic signed [DW-1:0] data;
      logic                 exp_valid;
   } vec_t;

   vec_t vecs [8];

   function automatic logic signed [DW-1:0] data_of(input int k);
      return DW'(-(k * 1000) - 7);
   endfunction

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_core(input int k, input logic [3:0] en, input logic signed [DW-1:0] d);
      io_out_bus[k*DW +: DW] = d;
      out_en_bus[k*EW +: EW] = en;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      out_en_bus = '0;
      clr_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Returns one negedge after the event edge, with enables cleared.
   task automatic fire(input logic [N-1:0] mask);
      @(negedge clk);
      for (int k = 0; k < N; k++)
         if (mask[k]) set_core(k, 4'd1, data_of(k));
      @(negedge clk);
      out_en_bus = '0;
   endtask

   task automatic expect_core(input string name, input int k, input logic signed [DW-1:0] d);
      @(negedge clk);
      check({name, " valid"}, 80'(dout_valid), 80'(1));
      check({name, " core"}, 80'(dout_core), 80'(k));
      check({name, " data"}, 80'(dout), 80'(d));
   endtask

   initial begin
      logic [N-1:0] m;

      vecs[0] = '{5,  4'd1,  -28'sd1234,   1'b1};
      vecs[1] = '{9,  4'd2,  28'sd111,     1'b0};
      vecs[2] = '{9,  4'hF,  28'sd222,     1'b0};
      vecs[3] = '{9,  4'd0,  28'sd333,     1'b0};
      vecs[4] = '{9,  4'd1,  28'sd777,     1'b1};
      vecs[5] = '{71, 4'd1,  28'sh7FFFFFF, 1'b1};
      vecs[6] = '{0,  4'd1,  28'sh8000000, 1'b1};
      vecs[7] = '{9,  4'd3,  28'sd444,     1'b0};

      rst_n = 1'b0;
      io_out_bus = '0;
      out_en_bus = '0;
      dout_ready = 1'b1;
      clr_err = 1'b0;
      #3;
      check("rst valid", 80'(dout_valid), 80'(0));
      check("rst level", 80'(fifo_level), 80'(0));
      check("rst dout", 80'(dout), 80'(0));
      check("rst core", 80'(dout_core), 80'(0));
      check("rst overrun", 80'(overrun), 80'(0));
      check("rst drops", 80'(drop_count), 80'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Single events: latency of two edges, enable decoding
      foreach (vecs[i]) begin
         @(negedge clk);
         set_core(vecs[i].core, vecs[i].en, vecs[i].data);
         @(negedge clk);
         out_en_bus = '0;
         check("vec early", 80'(dout_valid), 80'(0));
         @(negedge clk);
         check("vec valid", 80'(dout_valid), 80'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) begin
            check("vec core", 80'(dout_core), 80'(vecs[i].core));
            check("vec data", 80'(dout), 80'(vecs[i].data));
         end
         @(negedge clk);
         check("vec after", 80'(dout_valid), 80'(0));
      end

      // Round robin from rr_ptr=0, then from rr_ptr=70
      do_reset();
      m = '0; m[0] = 1'b1; m[1] = 1'b1; m[71] = 1'b1;
      fire(m);
      expect_core("rr0 a", 0, data_of(0));
      expect_core("rr0 b", 1, data_of(1));
      expect_core("rr0 c", 71, data_of(71));
      m = '0; m[0] = 1'b1; m[71] = 1'b1;
      fire(m);
      expect_core("rrwrap a", 0, data_of(0));
      expect_core("rrwrap b", 71, data_of(71));
      m = '0; m[69] = 1'b1;
      fire(m);
      expect_core("rr69", 69, data_of(69));
      m = '0; m[0] = 1'b1; m[1] = 1'b1; m[71] = 1'b1;
      fire(m);
      expect_core("rr70 a", 71, data_of(71));
      expect_core("rr70 b", 0, data_of(0));
      expect_core("rr70 c", 1, data_of(1));
      @(negedge clk);
      check("rr70 empty", 80'(dout_valid), 80'(0));

      // Backpressure: 20 events, 16 buffered, 4 held, none lost
      do_reset();
      dout_ready = 1'b0;
      m = '0;
      for (int k = 10; k < 30; k++) m[k] = 1'b1;
      fire(m);
      repeat (25) @(negedge clk);
      check("bp level", 80'(fifo_level), 80'(16));
      check("bp overrun", 80'(overrun), 80'(0));
      check("bp drops", 80'(drop_count), 80'(0));
      dout_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         check("bp valid", 80'(dout_valid), 80'(1));
         check("bp core", 80'(dout_core), 80'(10 + i));
         check("bp data", 80'(dout), 80'(data_of(10 + i)));
         @(negedge clk);
      end
      check("bp drained", 80'(dout_valid), 80'(0));
      check("bp level0", 80'(fifo_level), 80'(0));

      // Overrun with full FIFO, clear, clear racing a drop
      do_reset();
      dout_ready = 1'b0;
      m = '0;
      for (int k = 0; k < 16; k++) m[k] = 1'b1;
      fire(m);
      repeat (20) @(negedge clk);
      check("ov full", 80'(fifo_level), 80'(16));
      set_core(3, 4'd1, 28'sd12345);
      @(negedge clk);
      set_core(3, 4'd1, -28'sd999);
      @(negedge clk);
      out_en_bus = '0;
      check("ov flag", 80'(overrun), 80'(1) << 3);
      check("ov count", 80'(drop_count), 80'(1));
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("clr flag", 80'(overrun), 80'(0));
      check("clr count", 80'(drop_count), 80'(0));
      set_core(3, 4'd1, -28'sd5);
      @(negedge clk);
      check("ov2 count", 80'(drop_count), 80'(1));
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      out_en_bus = '0;
      check("clrrace flag", 80'(overrun), 80'(1) << 3);
      check("clrrace count", 80'(drop_count), 80'(1));
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("clr2 count", 80'(drop_count), 80'(0));
      dout_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("ov drain core", 80'(dout_core), 80'(i));
         @(negedge clk);
      end
      check("ov kept core", 80'(dout_core), 80'(3));
      check("ov kept data", 80'(dout), 80'(28'sd12345));
      @(negedge clk);
      check("ov empty", 80'(dout_valid), 80'(0));

      // Saturating drop counter with every core firing each cycle
      dout_ready = 1'b0;
      for (int k = 0; k < N; k++) set_core(k, 4'd1, data_of(k));
      repeat (1000) @(negedge clk);
      out_en_bus = '0;
      @(negedge clk);
      check("sat count", 80'(drop_count), 80'(16'hFFFF));
      check("sat overrun", 80'(overrun), 80'({N{1'b1}}));
      check("sat level", 80'(fifo_level), 80'(16));

      // Reset mid-stream
      do_reset();
      dout_ready = 1'b0;
      m = '0;
      for (int k = 40; k < 48; k++) m[k] = 1'b1;
      fire(m);
      repeat (10) @(negedge clk);
      check("mid level", 80'(fifo_level), 80'(8));
      #2;
      rst_n = 1'b0;
      #1;
      check("mid rst valid", 80'(dout_valid), 80'(0));
      check("mid rst level", 80'(fifo_level), 80'(0));
      check("mid rst dout", 80'(dout), 80'(0));
      check("mid rst drops", 80'(drop_count), 80'(0));
      @(negedge clk);
      rst_n = 1'b1;
      dout_ready = 1'b1;
      m = '0; m[42] = 1'b1;
      fire(m);
      expect_core("post rst", 42, data_of(42));
      @(negedge clk);
      check("post rst empty", 80'(dout_valid), 80'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
